// File: rtl/decode_stage_pkg.sv
// Shared encodings for the decode stage: instruction codes, register IDs,
// status codes and the bubble value the D/E register loads on reset or bubble.
package decode_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RESP  = 4'h4;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // Control half of the E register; the data words of a bubble are all zero.
    typedef struct packed {
        logic [2:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
        logic [3:0] src_a;
        logic [3:0] src_b;
    } e_ctrl_t;

    localparam e_ctrl_t E_BUBBLE_CTRL = '{
        stat:  S_BUB,
        icode: I_NOP,
        ifun:  4'h0,
        dst_e: RNONE,
        dst_m: RNONE,
        src_a: RNONE,
        src_b: RNONE
    };

endpackage

// File: rtl/decode_stage_fwd_select.sv
// Operand resolution for one source register: five prioritised forward paths
// falling back to the register file, with IDs outside the file reading zero.
module fwd_select #(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic [3:0]   src,
    input  logic [W-1:0] reg_val,
    input  logic [3:0]   e_dst_e,
    input  logic [W-1:0] e_val_e,
    input  logic [3:0]   m_dst_m,
    input  logic [W-1:0] m_val_m,
    input  logic [3:0]   m_dst_e,
    input  logic [W-1:0] m_val_e,
    input  logic [3:0]   w_dst_m,
    input  logic [W-1:0] w_val_m,
    input  logic [3:0]   w_dst_e,
    input  logic [W-1:0] w_val_e,
    output logic [W-1:0] val
);

    localparam int           NPATH   = 5;
    localparam logic [4:0]   NREG_ID = 5'(NREG);

    logic [3:0]   fwd_dst [NPATH];
    logic [W-1:0] fwd_val [NPATH];
    logic [NPATH-1:0] hit;
    logic src_valid;

    // Index 0 is the youngest result and therefore the highest priority.
    assign fwd_dst[0] = e_dst_e;  assign fwd_val[0] = e_val_e;
    assign fwd_dst[1] = m_dst_m;  assign fwd_val[1] = m_val_m;
    assign fwd_dst[2] = m_dst_e;  assign fwd_val[2] = m_val_e;
    assign fwd_dst[3] = w_dst_m;  assign fwd_val[3] = w_val_m;
    assign fwd_dst[4] = w_dst_e;  assign fwd_val[4] = w_val_e;

    assign src_valid = ({1'b0, src} < NREG_ID);

    generate
        for (genvar gi = 0; gi < NPATH; gi++) begin : g_hit
            assign hit[gi] = src_valid && (fwd_dst[gi] == src);
        end
    endgenerate

    always_comb begin
        val = src_valid ? reg_val : '0;
        for (int i = NPATH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                val = fwd_val[i];
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: picks source/destination register IDs, resolves operands with
// forwarding and latches the result into the D/E pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   D_stat,
    input  logic [3:0]   D_icode,
    input  logic [3:0]   D_ifun,
    input  logic [3:0]   D_rA,
    input  logic [3:0]   D_rB,
    input  logic [W-1:0] D_valC,
    input  logic [W-1:0] D_valP,
    input  logic [W-1:0] r0,
    input  logic [W-1:0] r1,
    input  logic [W-1:0] r2,
    input  logic [W-1:0] r3,
    input  logic [W-1:0] r4,
    input  logic [W-1:0] r5,
    input  logic [W-1:0] r6,
    input  logic [W-1:0] r7,
    input  logic [3:0]   e_dstE,
    input  logic [W-1:0] e_valE,
    input  logic [3:0]   M_dstM,
    input  logic [W-1:0] m_valM,
    input  logic [3:0]   M_dstE,
    input  logic [W-1:0] M_valE,
    input  logic [3:0]   W_dstM,
    input  logic [W-1:0] W_valM,
    input  logic [3:0]   W_dstE,
    input  logic [W-1:0] W_valE,
    input  logic         E_stall,
    input  logic         E_bubble,
    output logic [3:0]   d_srcA,
    output logic [3:0]   d_srcB,
    output logic [2:0]   E_stat,
    output logic [3:0]   E_icode,
    output logic [3:0]   E_ifun,
    output logic [W-1:0] E_valC,
    output logic [W-1:0] E_valA,
    output logic [W-1:0] E_valB,
    output logic [3:0]   E_dstE,
    output logic [3:0]   E_dstM,
    output logic [3:0]   E_srcA,
    output logic [3:0]   E_srcB
);

    logic [3:0]   src_a, src_b, dst_e, dst_m;
    logic [W-1:0] reg_file [8];
    logic [W-1:0] fwd_a, fwd_b, val_a;
    e_ctrl_t      ctrl_reg, ctrl_next;
    logic [W-1:0] val_c_reg, val_a_reg, val_b_reg;

    // Register ID selection; unlisted icodes leave every ID at RNONE.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            I_RRMOVL: begin
                src_a = D_rA;
                dst_e = D_rB;
            end
            I_IRMOVL: begin
                dst_e = D_rB;
            end
            I_RMMOVL: begin
                src_a = D_rA;
                src_b = D_rB;
            end
            I_MRMOVL: begin
                src_b = D_rB;
                dst_m = D_rA;
            end
            I_OPL: begin
                src_a = D_rA;
                src_b = D_rB;
                dst_e = D_rB;
            end
            I_CALL: begin
                src_b = RESP;
                dst_e = RESP;
            end
            I_RET: begin
                src_a = RESP;
                src_b = RESP;
                dst_e = RESP;
            end
            I_PUSHL: begin
                src_a = D_rA;
                src_b = RESP;
                dst_e = RESP;
            end
            I_POPL: begin
                src_a = RESP;
                src_b = RESP;
                dst_e = RESP;
                dst_m = D_rA;
            end
            default: begin
                src_a = RNONE;
            end
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    assign reg_file[0] = r0;
    assign reg_file[1] = r1;
    assign reg_file[2] = r2;
    assign reg_file[3] = r3;
    assign reg_file[4] = r4;
    assign reg_file[5] = r5;
    assign reg_file[6] = r6;
    assign reg_file[7] = r7;

    // Out-of-range IDs alias into the file here but are zeroed by fwd_select.
    fwd_select #(.W(W), .NREG(NREG)) u_fwd_a (
        .src     (src_a),
        .reg_val (reg_file[src_a[2:0]]),
        .e_dst_e (e_dstE),
        .e_val_e (e_valE),
        .m_dst_m (M_dstM),
        .m_val_m (m_valM),
        .m_dst_e (M_dstE),
        .m_val_e (M_valE),
        .w_dst_m (W_dstM),
        .w_val_m (W_valM),
        .w_dst_e (W_dstE),
        .w_val_e (W_valE),
        .val     (fwd_a)
    );

    fwd_select #(.W(W), .NREG(NREG)) u_fwd_b (
        .src     (src_b),
        .reg_val (reg_file[src_b[2:0]]),
        .e_dst_e (e_dstE),
        .e_val_e (e_valE),
        .m_dst_m (M_dstM),
        .m_val_m (m_valM),
        .m_dst_e (M_dstE),
        .m_val_e (M_valE),
        .w_dst_m (W_dstM),
        .w_val_m (W_valM),
        .w_dst_e (W_dstE),
        .w_val_e (W_valE),
        .val     (fwd_b)
    );

    // CALL and JXX carry the return/fall-through address in valA.
    assign val_a = ((D_icode == I_CALL) || (D_icode == I_JXX)) ? D_valP : fwd_a;

    always_comb begin
        ctrl_next       = E_BUBBLE_CTRL;
        ctrl_next.stat  = D_stat;
        ctrl_next.icode = D_icode;
        ctrl_next.ifun  = D_ifun;
        ctrl_next.dst_e = dst_e;
        ctrl_next.dst_m = dst_m;
        ctrl_next.src_a = src_a;
        ctrl_next.src_b = src_b;
    end

    // Stall takes precedence over bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_reg  <= E_BUBBLE_CTRL;
            val_c_reg <= '0;
            val_a_reg <= '0;
            val_b_reg <= '0;
        end else if (!E_stall) begin
            if (E_bubble) begin
                ctrl_reg  <= E_BUBBLE_CTRL;
                val_c_reg <= '0;
                val_a_reg <= '0;
                val_b_reg <= '0;
            end else begin
                ctrl_reg  <= ctrl_next;
                val_c_reg <= D_valC;
                val_a_reg <= val_a;
                val_b_reg <= fwd_b;
            end
        end
    end

    assign E_stat  = ctrl_reg.stat;
    assign E_icode = ctrl_reg.icode;
    assign E_ifun  = ctrl_reg.ifun;
    assign E_dstE  = ctrl_reg.dst_e;
    assign E_dstM  = ctrl_reg.dst_m;
    assign E_srcA  = ctrl_reg.src_a;
    assign E_srcB  = ctrl_reg.src_b;
    assign E_valC  = val_c_reg;
    assign E_valA  = val_a_reg;
    assign E_valB  = val_b_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, randomized run against a
// mask/list based reference model, and an asynchronous reset sequence.
module tb_decode_stage;

    typedef logic [3:0]  dst5_t [5];
    typedef logic [31:0] val5_t [5];

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [31:0] valC;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_t;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [31:0] valC;
        logic [31:0] valP;
        dst5_t       fd;
        val5_t       fv;
        logic        stall;
        logic        bubble;
        logic [3:0]  xsa;
        logic [3:0]  xsb;
        e_t          x;
    } vec_t;

    // Icode membership sets, one bit per icode.
    localparam logic [15:0] SA_RA  = 16'h0454;
    localparam logic [15:0] SA_SP  = 16'h0A00;
    localparam logic [15:0] SB_RB  = 16'h0070;
    localparam logic [15:0] SB_SP  = 16'h0F00;
    localparam logic [15:0] DE_RB  = 16'h004C;
    localparam logic [15:0] DE_SP  = 16'h0F00;
    localparam logic [15:0] DM_RA  = 16'h0820;
    localparam logic [15:0] NO_SET = 16'h0000;
    localparam logic [15:0] USE_P  = 16'h0180;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [31:0] D_valC, D_valP;
    logic [31:0] regs [8];
    logic [3:0]  fd [5];
    logic [31:0] fv [5];
    logic        E_stall, E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [31:0] E_valC, E_valA, E_valB;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    decode_stage #(.W(32), .NREG(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .D_stat   (D_stat),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP),
        .r0       (regs[0]),
        .r1       (regs[1]),
        .r2       (regs[2]),
        .r3       (regs[3]),
        .r4       (regs[4]),
        .r5       (regs[5]),
        .r6       (regs[6]),
        .r7       (regs[7]),
        .e_dstE   (fd[0]),
        .e_valE   (fv[0]),
        .M_dstM   (fd[1]),
        .m_valM   (fv[1]),
        .M_dstE   (fd[2]),
        .M_valE   (fv[2]),
        .W_dstM   (fd[3]),
        .W_valM   (fv[3]),
        .W_dstE   (fd[4]),
        .W_valE   (fv[4]),
        .E_stall  (E_stall),
        .E_bubble (E_bubble),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_stat   (E_stat),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_dstE   (E_dstE),
        .E_dstM   (E_dstM),
        .E_srcA   (E_srcA),
        .E_srcB   (E_srcB)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_e(input string tag, input e_t x);
        chk({tag, ".stat"},  32'(E_stat),  32'(x.stat));
        chk({tag, ".icode"}, 32'(E_icode), 32'(x.icode));
        chk({tag, ".ifun"},  32'(E_ifun),  32'(x.ifun));
        chk({tag, ".valC"},  E_valC,       x.valC);
        chk({tag, ".valA"},  E_valA,       x.valA);
        chk({tag, ".valB"},  E_valB,       x.valB);
        chk({tag, ".dstE"},  32'(E_dstE),  32'(x.dstE));
        chk({tag, ".dstM"},  32'(E_dstM),  32'(x.dstM));
        chk({tag, ".srcA"},  32'(E_srcA),  32'(x.srcA));
        chk({tag, ".srcB"},  32'(E_srcB),  32'(x.srcB));
    endtask

    function automatic e_t bubble_val();
        e_t b;
        b.stat = 3'd0; b.icode = 4'h1; b.ifun = 4'h0;
        b.valC = '0;   b.valA = '0;    b.valB = '0;
        b.dstE = 4'hF; b.dstM = 4'hF;  b.srcA = 4'hF; b.srcB = 4'hF;
        return b;
    endfunction

    function automatic logic [3:0] pick(input logic [15:0] use_r, input logic [15:0] use_sp,
                                        input logic [3:0] ic, input logic [3:0] r);
        if (use_r[ic])  return r;
        if (use_sp[ic]) return 4'h4;
        return 4'hF;
    endfunction

    // First matching forward in age order wins; out-of-file IDs read zero.
    function automatic logic [31:0] ref_read(input logic [3:0] src);
        if (src >= 4'd8) return 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (fd[i] == src) return fv[i];
        end
        return regs[src[2:0]];
    endfunction

    function automatic e_t ref_decode();
        e_t x;
        x.stat  = D_stat;
        x.icode = D_icode;
        x.ifun  = D_ifun;
        x.valC  = D_valC;
        x.srcA  = pick(SA_RA, SA_SP, D_icode, D_rA);
        x.srcB  = pick(SB_RB, SB_SP, D_icode, D_rB);
        x.dstE  = pick(DE_RB, DE_SP, D_icode, D_rB);
        x.dstM  = pick(DM_RA, NO_SET, D_icode, D_rA);
        x.valA  = USE_P[D_icode] ? D_valP : ref_read(x.srcA);
        x.valB  = ref_read(x.srcB);
        return x;
    endfunction

    vec_t vecs [10];
    e_t   model_e;

    initial begin
        dst5_t nof;
        val5_t zv;
        dst5_t d;
        val5_t v;
        e_t    bub;

        nof = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        zv  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bub = bubble_val();

        regs = '{32'hA0, 32'hA1, 32'h5, 32'h7, 32'h100, 32'hA5, 32'hA6, 32'hA7};

        vecs[0] = '{4'h6, 4'h0, 4'h2, 4'h3, 32'h0, 32'h0, nof, zv, 1'b0, 1'b0, 4'h2, 4'h3,
                    '{3'd1, 4'h6, 4'h0, 32'h0, 32'h5, 32'h7, 4'h3, 4'hF, 4'h2, 4'h3}};
        d = '{4'h2, 4'hF, 4'hF, 4'hF, 4'h2};
        v = '{32'h11, 32'h0, 32'h0, 32'h0, 32'h22};
        vecs[1] = '{4'h6, 4'h0, 4'h2, 4'h3, 32'h0, 32'h0, d, v, 1'b0, 1'b0, 4'h2, 4'h3,
                    '{3'd1, 4'h6, 4'h0, 32'h0, 32'h11, 32'h7, 4'h3, 4'hF, 4'h2, 4'h3}};
        d = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h2};
        vecs[2] = '{4'h6, 4'h0, 4'h2, 4'h3, 32'h0, 32'h0, d, v, 1'b0, 1'b0, 4'h2, 4'h3,
                    '{3'd1, 4'h6, 4'h0, 32'h0, 32'h22, 32'h7, 4'h3, 4'hF, 4'h2, 4'h3}};
        d = '{4'hF, 4'hF, 4'h4, 4'hF, 4'hF};
        v = '{32'h0, 32'h0, 32'hFC, 32'h0, 32'h0};
        vecs[3] = '{4'hA, 4'h0, 4'h1, 4'hF, 32'h0, 32'h0, d, v, 1'b0, 1'b0, 4'h1, 4'h4,
                    '{3'd1, 4'hA, 4'h0, 32'h0, 32'hA1, 32'hFC, 4'h4, 4'hF, 4'h1, 4'h4}};
        vecs[4] = '{4'h8, 4'h0, 4'hF, 4'hF, 32'h80, 32'h40, nof, zv, 1'b0, 1'b0, 4'hF, 4'h4,
                    '{3'd1, 4'h8, 4'h0, 32'h80, 32'h40, 32'h100, 4'h4, 4'hF, 4'hF, 4'h4}};
        vecs[5] = '{4'h3, 4'h0, 4'hF, 4'h5, 32'h1234, 32'h0, nof, zv, 1'b1, 1'b1, 4'hF, 4'hF,
                    vecs[4].x};
        vecs[6] = '{4'h3, 4'h0, 4'hF, 4'h5, 32'h1234, 32'h0, nof, zv, 1'b0, 1'b1, 4'hF, 4'hF,
                    bub};
        vecs[7] = '{4'h3, 4'h0, 4'hF, 4'h5, 32'h1234, 32'h0, nof, zv, 1'b0, 1'b0, 4'hF, 4'hF,
                    '{3'd1, 4'h3, 4'h0, 32'h1234, 32'h0, 32'h0, 4'h5, 4'hF, 4'hF, 4'hF}};
        d = '{4'hF, 4'h7, 4'hF, 4'h7, 4'hF};
        v = '{32'h0, 32'h55, 32'h0, 32'h77, 32'h0};
        vecs[8] = '{4'h5, 4'h0, 4'h6, 4'h7, 32'h8, 32'h0, d, v, 1'b0, 1'b0, 4'hF, 4'h7,
                    '{3'd1, 4'h5, 4'h0, 32'h8, 32'h0, 32'h55, 4'hF, 4'h6, 4'hF, 4'h7}};
        d = '{4'h9, 4'hF, 4'hF, 4'hF, 4'hF};
        v = '{32'h99, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[9] = '{4'h2, 4'h3, 4'h9, 4'h1, 32'h0, 32'h0, d, v, 1'b0, 1'b0, 4'h9, 4'hF,
                    '{3'd1, 4'h2, 4'h3, 32'h0, 32'h0, 32'h0, 4'h1, 4'hF, 4'h9, 4'hF}};

        D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = '0; D_valP = '0; fd = nof; fv = zv;
        E_stall = 1'b1; E_bubble = 1'b0;
        reset = 1'b1;

        // Reset lands between edges: E must show the bubble before any clock.
        #2 reset = 1'b0;
        #1 check_e("reset_async", bub);
        @(negedge clock);
        reset = 1'b1;
        E_stall = 1'b0;

        for (int n = 0; n < 10; n++) begin
            D_stat = 3'd1;
            D_icode = vecs[n].icode; D_ifun = vecs[n].ifun;
            D_rA = vecs[n].rA; D_rB = vecs[n].rB;
            D_valC = vecs[n].valC; D_valP = vecs[n].valP;
            fd = vecs[n].fd; fv = vecs[n].fv;
            E_stall = vecs[n].stall; E_bubble = vecs[n].bubble;
            #1;
            chk($sformatf("vec%0d.d_srcA", n), 32'(d_srcA), 32'(vecs[n].xsa));
            chk($sformatf("vec%0d.d_srcB", n), 32'(d_srcB), 32'(vecs[n].xsb));
            @(posedge clock);
            #1 check_e($sformatf("vec%0d", n), vecs[n].x);
            $display("vec %0d icode=%h stall=%0d bubble=%0d -> E_icode=%h E_valA=%h E_valB=%h",
                     n, vecs[n].icode, vecs[n].stall, vecs[n].bubble, E_icode, E_valA, E_valB);
            @(negedge clock);
        end

        model_e = vecs[9].x;
        for (int n = 0; n < 400; n++) begin
            e_t dec;
            for (int i = 0; i < 8; i++) regs[i] = $urandom;
            D_stat  = 3'($urandom_range(0, 4));
            D_icode = 4'($urandom);
            D_ifun  = 4'($urandom);
            D_rA    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            D_rB    = 4'($urandom);
            D_valC  = $urandom;
            D_valP  = $urandom;
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 3))
                    0:       fd[i] = D_rA;
                    1:       fd[i] = D_rB;
                    2:       fd[i] = 4'h4;
                    default: fd[i] = 4'($urandom);
                endcase
                fv[i] = $urandom;
            end
            E_stall  = ($urandom_range(0, 7) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            #1;
            dec = ref_decode();
            chk($sformatf("rnd%0d.d_srcA", n), 32'(d_srcA), 32'(dec.srcA));
            chk($sformatf("rnd%0d.d_srcB", n), 32'(d_srcB), 32'(dec.srcB));
            if (!E_stall) model_e = E_bubble ? bub : dec;
            @(posedge clock);
            #1 check_e($sformatf("rnd%0d", n), model_e);
            $display("rnd %0d icode=%h rA=%h rB=%h stall=%0d bubble=%0d -> E_valA=%h E_valB=%h",
                     n, D_icode, D_rA, D_rB, E_stall, E_bubble, E_valA, E_valB);
            @(negedge clock);
        end

        // Load a real instruction, then assert reset mid-cycle while stalled.
        regs = '{32'hA0, 32'hA1, 32'h5, 32'h7, 32'h100, 32'hA5, 32'hA6, 32'hA7};
        D_stat = 3'd1; D_icode = 4'h6; D_ifun = 4'h0; D_rA = 4'h2; D_rB = 4'h3;
        D_valC = '0; D_valP = '0; fd = nof; fv = zv;
        E_stall = 1'b0; E_bubble = 1'b0;
        @(posedge clock);
        #1 check_e("preload", vecs[0].x);
        @(negedge clock);
        E_stall = 1'b1;
        #2 reset = 1'b0;
        #1 check_e("reset_mid", bub);
        chk("reset_mid.d_srcA", 32'(d_srcA), 32'h2);
        $display("reset mid-run -> E_icode=%h E_stat=%h E_dstE=%h", E_icode, E_stat, E_dstE);
        @(negedge clock);
        E_stall = 1'b0;
        @(posedge clock);
        #1 check_e("reset_held", bub);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 check_e("after_reset", vecs[0].x);
        $display("after reset release -> E_icode=%h E_valA=%h E_valB=%h", E_icode, E_valA, E_valB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
